// File: rtl/mos6502_bus_pkg.sv
// Shared definitions for the MOS 6502 bus glue: the default 1 MHz region bounds
// and the state encoding of the slow-cycle stretcher.
package mos6502_bus_pkg;

  localparam logic [15:0] SLOW_BASE_DEFAULT  = 16'hFC00;
  localparam logic [15:0] SLOW_LIMIT_DEFAULT = 16'hFEFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ACCESS,
    ST_DONE
  } stretch_state_t;

  // Both bounds are inclusive.
  function automatic logic in_region(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input logic [15:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/addr_region_decode.sv
// Combinational address-window compare flagging CPU addresses that fall in the
// 1 MHz peripheral region.
module addr_region_decode
  import mos6502_bus_pkg::*;
#(
  parameter logic [15:0] SLOW_BASE  = SLOW_BASE_DEFAULT,
  parameter logic [15:0] SLOW_LIMIT = SLOW_LIMIT_DEFAULT
) (
  input  logic [15:0] Address_bus,
  output logic        hit
);

  assign hit = in_region(Address_bus, SLOW_BASE, SLOW_LIMIT);

endmodule

// File: rtl/slow_bus_stretch.sv
// Stretches 6502 cycles that target the 1 MHz region: READY is held low while
// the access is aligned to and run for one full 1 MHz period.
module slow_bus_stretch
  import mos6502_bus_pkg::*;
#(
  parameter logic [15:0] SLOW_BASE  = SLOW_BASE_DEFAULT,
  parameter logic [15:0] SLOW_LIMIT = SLOW_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        RES,
  input  logic        PHI_2,
  input  logic [15:0] Address_bus,
  input  logic        RnW,
  input  logic [7:0]  cpu_wdata,
  input  logic        ONE_MHZ_EN,
  input  logic [7:0]  slow_rdata,
  output logic        READY,
  output logic        slow_sel,
  output logic        slow_RnW,
  output logic [15:0] slow_addr,
  output logic [7:0]  slow_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdata_valid
);

  stretch_state_t state, state_next;

  logic phi2_prev;
  logic region_hit;
  logic slow_rise;
  logic latch_en;
  logic capture_en;
  logic ready_c;
  logic sel_c;

  addr_region_decode #(
    .SLOW_BASE  (SLOW_BASE),
    .SLOW_LIMIT (SLOW_LIMIT)
  ) u_decode (
    .Address_bus (Address_bus),
    .hit         (region_hit)
  );

  // phi2_prev resets high so a PHI_2 already high at release is not a rise.
  assign slow_rise = PHI_2 && !phi2_prev && region_hit;

  always_ff @(posedge clk or posedge RES) begin
    if (RES) begin
      state     <= ST_IDLE;
      phi2_prev <= 1'b1;
    end else begin
      state     <= state_next;
      phi2_prev <= PHI_2;
    end
  end

  always_comb begin
    state_next = state;
    ready_c    = 1'b1;
    sel_c      = 1'b0;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (slow_rise) begin
          latch_en   = 1'b1;
          ready_c    = 1'b0;
          state_next = ONE_MHZ_EN ? ST_ACCESS : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        ready_c = 1'b0;
        if (ONE_MHZ_EN) begin
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ready_c = 1'b0;
        sel_c   = 1'b1;
        if (ONE_MHZ_EN) begin
          capture_en = slow_RnW;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Latches only load from IDLE, so they cannot move while slow_sel is high.
  always_ff @(posedge clk or posedge RES) begin
    if (RES) begin
      slow_RnW   <= 1'b1;
      slow_addr  <= '0;
      slow_wdata <= '0;
      cpu_rdata  <= '0;
    end else begin
      if (latch_en) begin
        slow_RnW   <= RnW;
        slow_addr  <= Address_bus;
        slow_wdata <= cpu_wdata;
      end
      if (capture_en) begin
        cpu_rdata <= slow_rdata;
      end
    end
  end

  assign READY           = ready_c;
  assign slow_sel        = sel_c;
  assign cpu_rdata_valid = (state == ST_DONE) && slow_RnW;

endmodule

// File: tb/tb_slow_bus_stretch.sv
// Directed self-checking bench for slow_bus_stretch: fast/slow classification,
// stall lengths, latched values, read-data return and reset abort.
module tb_slow_bus_stretch;

  logic        clk;
  logic        RES;
  logic        PHI_2;
  logic [15:0] Address_bus;
  logic        RnW;
  logic [7:0]  cpu_wdata;
  logic        ONE_MHZ_EN;
  logic [7:0]  slow_rdata;
  logic        READY;
  logic        slow_sel;
  logic        slow_RnW;
  logic [15:0] slow_addr;
  logic [7:0]  slow_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdata_valid;

  int test_count = 0;
  int fail_count = 0;

  slow_bus_stretch dut (
    .clk             (clk),
    .RES             (RES),
    .PHI_2           (PHI_2),
    .Address_bus     (Address_bus),
    .RnW             (RnW),
    .cpu_wdata       (cpu_wdata),
    .ONE_MHZ_EN      (ONE_MHZ_EN),
    .slow_rdata      (slow_rdata),
    .READY           (READY),
    .slow_sel        (slow_sel),
    .slow_RnW        (slow_RnW),
    .slow_addr       (slow_addr),
    .slow_wdata      (slow_wdata),
    .cpu_rdata       (cpu_rdata),
    .cpu_rdata_valid (cpu_rdata_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Presents one CPU cycle with a PHI_2 rise, then paces ONE_MHZ_EN (first pulse
  // en_delay clks after the rise, then every 16) until READY returns high.
  task automatic applyStimulus(input logic [15:0] addr, input logic rnw,
                               input logic [7:0] wdata, input logic [7:0] rdata,
                               input int en_delay,
                               output logic rise_ready, output int stall,
                               output int sel_clks, output logic [7:0] done_rdata,
                               output logic done_valid, output logic [15:0] lat_addr,
                               output logic lat_rnw, output logic [7:0] lat_wdata,
                               output logic lat_stable);
    bit first_sel;
    Address_bus = addr;
    RnW         = rnw;
    cpu_wdata   = wdata;
    slow_rdata  = rdata;
    PHI_2       = 1'b1;
    ONE_MHZ_EN  = (en_delay == 0);
    @(negedge clk);
    rise_ready = READY;
    @(posedge clk);
    #1;
    Address_bus = ~addr;
    RnW         = ~rnw;
    cpu_wdata   = ~wdata;
    stall       = 0;
    sel_clks    = 0;
    done_rdata  = '0;
    done_valid  = 1'b0;
    lat_addr    = '0;
    lat_rnw     = 1'b1;
    lat_wdata   = '0;
    lat_stable  = 1'b1;
    first_sel   = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      ONE_MHZ_EN = (c >= en_delay) && (((c - en_delay) % 16) == 0);
      PHI_2      = (c % 4) < 2;
      @(negedge clk);
      if (READY) begin
        done_rdata = cpu_rdata;
        done_valid = cpu_rdata_valid;
        break;
      end
      stall++;
      if (slow_sel) begin
        sel_clks++;
        if (first_sel) begin
          lat_addr  = slow_addr;
          lat_rnw   = slow_RnW;
          lat_wdata = slow_wdata;
          first_sel = 1'b0;
        end else if (slow_addr !== lat_addr || slow_RnW !== lat_rnw ||
                     slow_wdata !== lat_wdata) begin
          lat_stable = 1'b0;
        end
      end
      @(posedge clk);
      #1;
    end
    ONE_MHZ_EN  = 1'b0;
    PHI_2       = 1'b0;
    Address_bus = 16'h0200;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic        r_ready;
  int          r_stall;
  int          r_sel;
  logic [7:0]  r_rdata;
  logic        r_valid;
  logic [15:0] r_addr;
  logic        r_rnw;
  logic [7:0]  r_wdata;
  logic        r_stable;

  typedef struct {
    logic [15:0] addr;
    logic        slow;
  } boundary_t;

  boundary_t bounds [4];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sel_after;
    int low_after;

    RES         = 1'b1;
    PHI_2       = 1'b0;
    Address_bus = 16'h0000;
    RnW         = 1'b1;
    cpu_wdata   = 8'h00;
    ONE_MHZ_EN  = 1'b0;
    slow_rdata  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", READY, 1);
    checkOutput("rst_sel", slow_sel, 0);
    checkOutput("rst_rnw", slow_RnW, 1);
    checkOutput("rst_addr", slow_addr, 0);
    checkOutput("rst_wdata", slow_wdata, 0);
    checkOutput("rst_rdata", cpu_rdata, 0);
    checkOutput("rst_valid", cpu_rdata_valid, 0);
    @(negedge clk);
    RES = 1'b0;
    @(posedge clk);
    #1;

    // Fast cycle: no stall, no strobe.
    applyStimulus(16'h0200, 1'b1, 8'h00, 8'h77, 0,
                  r_ready, r_stall, r_sel, r_rdata, r_valid, r_addr, r_rnw, r_wdata, r_stable);
    checkOutput("fast_rise_ready", r_ready, 1);
    checkOutput("fast_stall", r_stall, 0);
    checkOutput("fast_sel", r_sel, 0);

    // Read &FE40 with EN 3 clks after the rise: 3 + 16 stalled clks.
    applyStimulus(16'hFE40, 1'b1, 8'h00, 8'hA5, 3,
                  r_ready, r_stall, r_sel, r_rdata, r_valid, r_addr, r_rnw, r_wdata, r_stable);
    checkOutput("rd_rise_ready", r_ready, 0);
    checkOutput("rd_stall", r_stall, 19);
    checkOutput("rd_sel_clks", r_sel, 16);
    checkOutput("rd_addr", r_addr, 16'hFE40);
    checkOutput("rd_rnw", r_rnw, 1);
    checkOutput("rd_stable", r_stable, 1);
    checkOutput("rd_rdata", r_rdata, 8'hA5);
    checkOutput("rd_valid", r_valid, 1);

    // Write &FC00 with EN coincident: straight to ACCESS, 16 stalled clks.
    applyStimulus(16'hFC00, 1'b0, 8'h3C, 8'h5A, 0,
                  r_ready, r_stall, r_sel, r_rdata, r_valid, r_addr, r_rnw, r_wdata, r_stable);
    checkOutput("wr_rise_ready", r_ready, 0);
    checkOutput("wr_stall", r_stall, 16);
    checkOutput("wr_sel_clks", r_sel, 16);
    checkOutput("wr_addr", r_addr, 16'hFC00);
    checkOutput("wr_rnw", r_rnw, 0);
    checkOutput("wr_wdata", r_wdata, 8'h3C);
    checkOutput("wr_stable", r_stable, 1);
    checkOutput("wr_valid", r_valid, 0);
    checkOutput("wr_rdata_held", r_rdata, 8'hA5);

    // Region boundaries.
    bounds[0] = '{16'hFBFF, 1'b0};
    bounds[1] = '{16'hFC00, 1'b1};
    bounds[2] = '{16'hFEFF, 1'b1};
    bounds[3] = '{16'hFF00, 1'b0};
    foreach (bounds[i]) begin
      applyStimulus(bounds[i].addr, 1'b1, 8'h00, 8'h10 + 8'(i), 0,
                    r_ready, r_stall, r_sel, r_rdata, r_valid, r_addr, r_rnw, r_wdata, r_stable);
      checkOutput($sformatf("bound_%04h_stall", bounds[i].addr), r_stall,
                  bounds[i].slow ? 16 : 0);
      checkOutput($sformatf("bound_%04h_sel", bounds[i].addr), r_sel,
                  bounds[i].slow ? 16 : 0);
    end

    // Two consecutive slow reads, each with its own data.
    applyStimulus(16'hFE00, 1'b1, 8'h00, 8'h11, 5,
                  r_ready, r_stall, r_sel, r_rdata, r_valid, r_addr, r_rnw, r_wdata, r_stable);
    checkOutput("b2b0_stall", r_stall, 21);
    checkOutput("b2b0_addr", r_addr, 16'hFE00);
    checkOutput("b2b0_rdata", r_rdata, 8'h11);
    checkOutput("b2b0_valid", r_valid, 1);
    applyStimulus(16'hFE01, 1'b1, 8'h00, 8'h22, 1,
                  r_ready, r_stall, r_sel, r_rdata, r_valid, r_addr, r_rnw, r_wdata, r_stable);
    checkOutput("b2b1_stall", r_stall, 17);
    checkOutput("b2b1_sel", r_sel, 16);
    checkOutput("b2b1_addr", r_addr, 16'hFE01);
    checkOutput("b2b1_rdata", r_rdata, 8'h22);
    checkOutput("b2b1_valid", r_valid, 1);

    // Reset 5 clks into an ACCESS of &FEFF aborts it without a later strobe.
    Address_bus = 16'hFEFF;
    RnW         = 1'b1;
    PHI_2       = 1'b1;
    ONE_MHZ_EN  = 1'b1;
    @(posedge clk);
    #1;
    ONE_MHZ_EN  = 1'b0;
    PHI_2       = 1'b0;
    Address_bus = 16'h0200;
    repeat (5) @(posedge clk);
    #3;
    checkOutput("abort_pre_sel", slow_sel, 1);
    RES = 1'b1;
    #1;
    checkOutput("abort_ready", READY, 1);
    checkOutput("abort_sel", slow_sel, 0);
    checkOutput("abort_addr", slow_addr, 0);
    @(negedge clk);
    RES       = 1'b0;
    sel_after = 0;
    low_after = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      ONE_MHZ_EN = ((c % 16) == 5);
      @(negedge clk);
      if (slow_sel) sel_after++;
      if (!READY) low_after++;
    end
    ONE_MHZ_EN = 1'b0;
    checkOutput("abort_no_strobe", sel_after, 0);
    checkOutput("abort_no_stall", low_after, 0);

    // First rise after release is evaluated normally.
    applyStimulus(16'hFD80, 1'b1, 8'h00, 8'hC3, 2,
                  r_ready, r_stall, r_sel, r_rdata, r_valid, r_addr, r_rnw, r_wdata, r_stable);
    checkOutput("post_rst_stall", r_stall, 18);
    checkOutput("post_rst_rdata", r_rdata, 8'hC3);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/slow_bus_stretch.md
SLOW_BUS_STRETCH -- requirements
Module: slow_bus_stretch

Interface
REQ-001 SHALL have parameter SLOW_BASE, default 16'hFC00, lowest address of the 1 MHz region.
REQ-002 SHALL have parameter SLOW_LIMIT, default 16'hFEFF, highest address of the 1 MHz region (inclusive).
REQ-003 SHALL have port clk, input, 1, single system clock; all state on rising edge.
REQ-004 SHALL have port RES, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port PHI_2, input, 1, CPU phase-2 from MOS_6502.
REQ-006 SHALL have port Address_bus, input, 16, CPU address.
REQ-007 SHALL have port RnW, input, 1, CPU read(1)/write(0).
REQ-008 SHALL have port cpu_wdata, input, 8, CPU write data.
REQ-009 SHALL have port ONE_MHZ_EN, input, 1, one-clk pulse marking each 1 MHz period boundary.
REQ-010 SHALL have port slow_rdata, input, 8, peripheral read data.
REQ-011 SHALL have port READY, output, 1, to MOS_6502 READY; low stalls CPU.
REQ-012 SHALL have port slow_sel, output, 1, peripheral access strobe.
REQ-013 SHALL have port slow_RnW, output, 1, latched direction.
REQ-014 SHALL have port slow_addr, output, 16, latched address.
REQ-015 SHALL have port slow_wdata, output, 8, latched write data.
REQ-016 SHALL have port cpu_rdata, output, 8, held read data returned to CPU.
REQ-017 SHALL have port cpu_rdata_valid, output, 1, cpu_rdata must be muxed onto Data_bus.

Function
REQ-018 SHALL detect a PHI_2 rise as PHI_2=1 with registered previous PHI_2=0.
REQ-019 SHALL classify a cycle as slow when SLOW_BASE <= Address_bus <= SLOW_LIMIT at the detected rise, reads, writes and opcode fetches alike.
REQ-020 SHALL implement states IDLE, ALIGN, ACCESS, DONE.
REQ-021 IDLE: on slow rise, latch address, RnW, cpu_wdata; go to ACCESS if ONE_MHZ_EN is high that same clk, else ALIGN.
REQ-022 ALIGN: hold until ONE_MHZ_EN, then ACCESS.
REQ-023 ACCESS: slow_sel=1 for one full 1 MHz period; on next ONE_MHZ_EN capture slow_rdata (read only) and go to DONE.
REQ-024 DONE: READY=1, cpu_rdata_valid=1 for a read, for exactly one clk; then IDLE.
REQ-025 READY SHALL fall combinationally in the clk of the slow rise, remain low through ALIGN and ACCESS, and rise in DONE.
REQ-026 Non-slow cycles SHALL leave READY=1 and the FSM in IDLE with zero added latency.
REQ-027 PHI_2 rises while not IDLE SHALL be ignored (CPU is stalled).
REQ-028 Back-to-back slow cycles SHALL each be independently stretched; a rise in the clk after DONE re-enters from IDLE.
REQ-029 Latched outputs SHALL not change while slow_sel=1.
REQ-030 Stretch length SHALL be 1 to 2 ONE_MHZ_EN periods, never unbounded given a periodic ONE_MHZ_EN.

Reset
REQ-031 RES high SHALL immediately force IDLE, READY=1, slow_sel=0, slow_RnW=1, slow_addr=0, slow_wdata=0, cpu_rdata=0, cpu_rdata_valid=0.
REQ-032 RES asserted mid-ALIGN/ACCESS SHALL abort the access without a further slow_sel pulse after release.
REQ-033 The first PHI_2 edge after RES release SHALL be evaluated normally (previous-PHI_2 register resets to 1).

Structure
REQ-034 Region constants and the state enum SHALL live in shared package mos6502_bus_pkg.
REQ-035 Address range compare SHALL be sub-module addr_region_decode (Address_bus in, hit out).

Verification
REQ-036 Read &0200, PHI_2 rise -> READY stays 1, slow_sel never asserts.
REQ-037 Read &FE40, ONE_MHZ_EN 3 clks later, period 16 clks, slow_rdata=8'hA5 -> READY low for 3+16 clks, cpu_rdata=8'hA5 with valid in DONE.
REQ-038 Write 8'h3C to &FC00 with ONE_MHZ_EN coincident with rise -> direct ACCESS, slow_wdata=8'h3C, slow_RnW=0, READY low 16 clks.
REQ-039 RES pulsed 5 clks into ACCESS of &FEFF -> READY=1, slow_sel=0 immediately; no strobe afterwards.
REQ-040 Boundaries &FBFF and &FF00 -> not stretched; &FC00 and &FEFF -> stretched.
REQ-041 Two consecutive slow reads &FE00,&FE01 -> two separate ACCESS periods, each returning its own slow_rdata.
